// File: rtl/prim_fifo_sync_wm.sv
// Synchronous FIFO with optional same-cycle pass-through, watermark flags,
// high-water mark and sticky overflow flag.
//
// Parameters:
//   Width             data bits per entry
//   Depth             number of storage entries (any value >= 1)
//   Pass              1: a write into an empty FIFO is visible on the read port the same cycle
//   OutputZeroIfEmpty 1: rdata_o reads as zero whenever rvalid_o is low
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   clr_i                              synchronous flush (pointers, depth, max depth, overflow)
//   wvalid_i / wready_o / wdata_i      write handshake
//   rvalid_o / rready_i / rdata_o      read handshake, rdata_o is the head entry
//   depth_o, full_o, empty_o           occupancy status from registered state
//   afull_thresh_i, aempty_thresh_i    watermark thresholds
//   afull_o, aempty_o                  depth_o >= afull_thresh_i, depth_o <= aempty_thresh_i
//   max_depth_o                        registered high-water mark of depth_o
//   ovf_o                              sticky: a write was attempted while full
module prim_fifo_sync_wm #(
  parameter int unsigned Width             = 16,
  parameter int unsigned Depth             = 4,
  parameter bit          Pass              = 1'b1,
  parameter bit          OutputZeroIfEmpty = 1'b0,
  localparam int unsigned DepthW           = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  output logic [DepthW-1:0] depth_o,
  output logic              full_o,
  output logic              empty_o,
  input  logic [DepthW-1:0] afull_thresh_i,
  input  logic [DepthW-1:0] aempty_thresh_i,
  output logic              afull_o,
  output logic              aempty_o,
  output logic [DepthW-1:0] max_depth_o,
  output logic              ovf_o
);

  if (Depth == 0) begin : gen_depth_zero
    $error("prim_fifo_sync_wm: Depth must be at least 1");
  end

  localparam int unsigned       PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [DepthW-1:0] DepthMax = DepthW'(Depth);
  localparam logic [PtrW-1:0]   PtrLast  = PtrW'(Depth - 1);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic [DepthW-1:0] max_depth_q, max_depth_d;
  logic              ovf_q, ovf_d;

  logic pass_en;
  logic wr_en;
  logic rd_en;
  logic bypass;
  logic push;
  logic pop;

  // Status is derived from registered depth only, so it resets asynchronously.
  assign depth_o  = depth_q;
  assign empty_o  = (depth_q == '0);
  assign full_o   = (depth_q == DepthMax);
  assign wready_o = ~full_o;

  // Pass-through applies only while storage is empty; the head otherwise comes from memory.
  assign pass_en  = Pass && empty_o && wvalid_i;
  assign rvalid_o = ~empty_o | pass_en;

  assign wr_en  = wvalid_i & wready_o;
  assign rd_en  = rvalid_o & rready_i;
  // A pass-through entry consumed in the same cycle never touches storage.
  assign bypass = pass_en & rd_en;
  assign push   = wr_en & ~bypass;
  assign pop    = rd_en & ~bypass;

  assign afull_o     = (depth_q >= afull_thresh_i);
  assign aempty_o    = (depth_q <= aempty_thresh_i);
  assign max_depth_o = max_depth_q;
  assign ovf_o       = ovf_q;

  always_comb begin
    rdata_o = pass_en ? wdata_i : mem_q[rptr_q];
    if (OutputZeroIfEmpty && !rvalid_o) begin
      rdata_o = '0;
    end
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    depth_d     = depth_q;
    max_depth_d = (depth_q > max_depth_q) ? depth_q : max_depth_q;
    ovf_d       = ovf_q | (wvalid_i & ~wready_o);

    if (push) begin
      wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
    end

    unique case ({push, pop})
      2'b10:   depth_d = depth_q + DepthW'(1);
      2'b01:   depth_d = depth_q - DepthW'(1);
      default: depth_d = depth_q;
    endcase

    // Flush wins over any simultaneous transfer.
    if (clr_i) begin
      wptr_d      = '0;
      rptr_d      = '0;
      depth_d     = '0;
      max_depth_d = '0;
      ovf_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      depth_q     <= '0;
      max_depth_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      depth_q     <= depth_d;
      max_depth_q <= max_depth_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage is deliberately not reset; entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (push && !clr_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  a_depth_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) depth_o <= DepthMax);
  a_depth_known: assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(depth_o));
  a_rvalid_known: assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(rvalid_o));
  a_wready_known: assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(wready_o));

endmodule
